multicycle_ctrl: RTL

Multi-cycle control FSM that sequences the 8-bit register-file/ALU datapath through fetch, decode, execute, memory and writeback for an RV32I subset. It owns the PC and instruction register, handshakes with instruction and data memory, and drives every datapath control and operand-select input. It sits between the memory ports and the datapath in the core top level.

---
 rtl/multicycle_ctrl.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: IDLE/FETCH/DECODE/EXEC/MEM/WB/HALT sequencer for RV32I subset.
// Define CTRL_PERF_CNT_EN to add cycle_cnt / instret_cnt performance counters.
module multicycle_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int IMM_WIDTH  = 8,
  parameter int RS_WIDTH   = 5,
  parameter int ALU_WIDTH  = 4,
  parameter int PC_WIDTH   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 imem_req,
  output logic [PC_WIDTH-1:0]  imem_addr,
  input  logic                 imem_ack,
  input  logic [31:0]          imem_rdata,
  output logic                 dmem_req,
  output logic                 dmem_we,
  input  logic                 dmem_ack,
  input  logic                 zero,
  output logic [RS_WIDTH-1:0]  RS1,
  output logic [RS_WIDTH-1:0]  RS2,
  output logic [RS_WIDTH-1:0]  RD,
  output logic [IMM_WIDTH-1:0] IMM,
  output logic [ALU_WIDTH-1:0] ALUControl,
  output logic                 regWrite,
  output logic                 ALUSrc,
  output logic                 memToReg,
  output logic                 jalSrc,
  output logic [PC_WIDTH-1:0]  ra,
  output logic                 halt,
  output logic                 illegal,
  output logic [31:0]          cycle_cnt,
  output logic [31:0]          instret_cnt
);

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT
  } state_t;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_SYS = 7'b1110011;

  if (IMM_WIDTH > DATA_WIDTH) begin : g_imm_chk
    $error("IMM_WIDTH exceeds DATA_WIDTH");
  end

  state_t state, state_nxt;
  logic [31:0] ir;
  logic [PC_WIDTH-1:0] pc, pc_nxt, pc_4, pc_imm;
  logic ill_q, ill_set;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic is_r, is_i, is_lw, is_sw;
  logic is_beq, is_jal, is_sys;
  logic legal;
  logic [3:0] alu;
  logic signed [20:0] imm_raw;

  assign opcode = ir[6:0];
  assign funct3 = ir[14:12];
  assign is_r   = opcode == OP_R;
  assign is_i   = opcode == OP_I;
  assign is_lw  = opcode == OP_LW;
  assign is_sw  = opcode == OP_SW;
  assign is_beq = opcode == OP_BEQ;
  assign is_jal = opcode == OP_JAL;
  assign is_sys = opcode == OP_SYS;

  // ALU op, legality and sign-extended immediate from IR
  always_comb begin
    alu     = 4'b0000;
    legal   = 1'b1;
    imm_raw = '0;
    unique case (1'b1)
      is_r: begin
        unique case (funct3)
          3'b000:  alu = ir[30] ? 4'b0110 : 4'b0010;
          3'b111:  alu = 4'b0000;
          3'b110:  alu = 4'b0001;
          3'b100:  alu = 4'b0100;
          3'b101:  alu = 4'b0011;
          3'b010:  alu = 4'b0111;
          default: legal = 1'b0;
        endcase
      end
      is_i: begin
        imm_raw = 21'($signed(ir[31:20]));
        unique case (funct3)
          3'b000:  alu = 4'b0010;
          3'b101:  alu = 4'b0011;
          3'b010:  alu = 4'b0111;
          default: legal = 1'b0;
        endcase
      end
      is_lw: begin
        alu     = 4'b0010;
        imm_raw = 21'($signed(ir[31:20]));
      end
      is_sw: begin
        alu     = 4'b0010;
        imm_raw = 21'($signed({ir[31:25], ir[11:7]}));
      end
      is_beq: begin
        alu     = 4'b0110;
        legal   = funct3 == 3'b000;
        imm_raw = 21'($signed({ir[31], ir[7],
                  ir[30:25], ir[11:8], 1'b0}));
      end
      is_jal: begin
        imm_raw = $signed({ir[31], ir[19:12],
                  ir[20], ir[30:21], 1'b0});
      end
      is_sys:  legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  assign pc_4   = pc + PC_WIDTH'(4);
  assign pc_imm = pc + PC_WIDTH'(imm_raw);

  // Next state and next PC
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    ill_set   = 1'b0;
    unique case (state)
      IDLE:  state_nxt = FETCH;
      FETCH: if (imem_ack) state_nxt = DECODE;
      DECODE: begin
        if (is_sys || !legal) begin
          state_nxt = HALT;
          ill_set   = !legal;
        end else begin
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        unique case (1'b1)
          is_lw, is_sw: state_nxt = MEM;
          is_beq: begin
            pc_nxt    = zero ? pc_imm : pc_4;
            state_nxt = FETCH;
          end
          is_jal: begin
            pc_nxt    = pc_imm;
            state_nxt = FETCH;
          end
          default: state_nxt = WB;
        endcase
      end
      MEM: begin
        if (dmem_ack) begin
          if (is_sw) begin
            pc_nxt    = pc_4;
            state_nxt = FETCH;
          end else begin
            state_nxt = WB;
          end
        end
      end
      WB: begin
        pc_nxt    = pc_4;
        state_nxt = FETCH;
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
  end

  // State, PC, IR and sticky illegal flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pc    <= '0;
      ir    <= '0;
      ill_q <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (state == FETCH && imem_ack) ir <= imem_rdata;
      if (ill_set) ill_q <= 1'b1;
    end
  end

  assign imem_req   = state == FETCH;
  assign imem_addr  = pc;
  assign dmem_req   = state == MEM;
  assign dmem_we    = (state == MEM) && is_sw;
  assign regWrite   = state == WB;
  assign memToReg   = (state == WB) && is_lw;
  assign jalSrc     = (state == EXEC) && is_jal;
  assign ra         = jalSrc ? pc_4 : '0;
  assign halt       = state == HALT;
  assign illegal    = ill_q;
  assign ALUSrc     = is_i || is_lw || is_sw;
  assign ALUControl = ALU_WIDTH'(alu);
  assign RS1        = RS_WIDTH'(ir[19:15]);
  assign RS2        = RS_WIDTH'(ir[24:20]);
  assign RD         = RS_WIDTH'(ir[11:7]);
  assign IMM        = IMM_WIDTH'(imm_raw);

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] cyc_q, ret_q;

  // Cycle and retired-instruction counters
  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_q <= '0;
      ret_q <= '0;
    end else begin
      if (state != HALT) cyc_q <= cyc_q + 32'd1;
      if (state_nxt == FETCH &&
          (state == EXEC || state == MEM ||
           state == WB))
        ret_q <= ret_q + 32'd1;
    end
  end

  assign cycle_cnt   = cyc_q;
  assign instret_cnt = ret_q;
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif

endmodule
